// File: rtl/operand_fetch.sv
// operand_fetch: decode/issue stage between an instruction source and execute.
//
// Holds a 16-entry scoreboard of in-flight destination registers, stalls on
// read-after-write and write-after-write hazards, optionally forwards the
// writeback bus into the operands, and holds one registered operand bundle
// for the execute stage under a valid/ready handshake.
//
// Ports
//   clk                       single clock, rising edge
//   reset                     asynchronous, active-low
//   instr_valid/instr         upstream instruction and its valid flag
//   instr_ready               combinational accept for the current instruction
//   rf_readReg1/2             register file read addresses (rs1/rs2 of instr)
//   rf_readData1/2            register file read data
//   wb_valid/wb_reg/wb_data   writeback bus (also drives the register file)
//   ex_valid/ex_ready         operand bundle handshake to execute
//   ex_opcode/rd/opA/opB/imm  registered operand bundle
//   flush                     discard the held bundle
//   stall_cnt                 saturating count of hazard-stall cycles
module operand_fetch #(
  parameter int BYPASS_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rf_readReg1,
  output logic [3:0]  rf_readReg2,
  input  logic [31:0] rf_readData1,
  input  logic [31:0] rf_readData2,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_rd,
  output logic [31:0] ex_opA,
  output logic [31:0] ex_opB,
  output logic [15:0] ex_imm,
  input  logic        flush,
  output logic [15:0] stall_cnt
);

  localparam logic       BYP        = (BYPASS_EN != 0);
  localparam logic [3:0] OP_NOP     = 4'hF;
  localparam logic [3:0] OP_LAST_WR = 4'hB;

  logic [3:0]  opcode, rd, rs1, rs2;
  logic [15:0] imm;
  logic        writes_rd, reads_src;
  logic        byp1, byp2, rs1_ok, rs2_ok, rd_ok;
  logic        hazard, issue;
  logic        ex_writes_rd;
  logic [15:0] busy, busy_next;

  assign opcode = instr[31:28];
  assign rd     = instr[27:24];
  assign rs1    = instr[23:20];
  assign rs2    = instr[19:16];
  assign imm    = instr[15:0];

  assign rf_readReg1 = rs1;
  assign rf_readReg2 = rs2;

  assign writes_rd    = (opcode <= OP_LAST_WR);
  assign reads_src    = (opcode != OP_NOP);
  assign ex_writes_rd = (ex_opcode <= OP_LAST_WR);

  assign byp1 = BYP && wb_valid && (wb_reg == rs1);
  assign byp2 = BYP && wb_valid && (wb_reg == rs2);

  assign rs1_ok = !busy[rs1] || byp1;
  assign rs2_ok = !busy[rs2] || byp2;
  // A pending destination may be re-targeted in the cycle its writeback
  // lands: the clear and the new set coincide and the set wins.
  assign rd_ok  = !busy[rd] || (wb_valid && (wb_reg == rd));

  assign hazard = instr_valid && reads_src &&
                  (!rs1_ok || !rs2_ok || (writes_rd && !rd_ok));

  assign instr_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign issue       = instr_valid && instr_ready;

  // Order matters: writeback clear, then flush clear, then issue set.
  always_comb begin
    busy_next = busy;
    if (wb_valid)
      busy_next[wb_reg] = 1'b0;
    if (flush && ex_valid && ex_writes_rd)
      busy_next[ex_rd] = 1'b0;
    if (issue && writes_rd)
      busy_next[rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= '0;
      stall_cnt <= '0;
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_rd     <= '0;
      ex_opA    <= '0;
      ex_opB    <= '0;
      ex_imm    <= '0;
    end else begin
      busy <= busy_next;

      if (hazard && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;

      if (flush) begin
        ex_valid <= 1'b0;
      end else if (issue) begin
        ex_valid  <= 1'b1;
        ex_opcode <= opcode;
        ex_rd     <= rd;
        ex_opA    <= byp1 ? wb_data : rf_readData1;
        ex_opB    <= byp2 ? wb_data : rf_readData2;
        ex_imm    <= imm;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch. Instance u_byp has forwarding enabled,
// instance u_nobyp has it disabled; both see the same inputs and a shared
// register file model addressed by u_byp.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        flush;

  logic        instr_ready, ex_valid;
  logic [3:0]  rr1, rr2, ex_opcode, ex_rd;
  logic [31:0] ex_opA, ex_opB;
  logic [15:0] ex_imm, stall_cnt;

  logic        instr_ready_b, ex_valid_b;
  logic [3:0]  rr1_b, rr2_b, ex_opcode_b, ex_rd_b;
  logic [31:0] ex_opA_b, ex_opB_b;
  logic [15:0] ex_imm_b, stall_cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rf [16] = '{32'h100, 32'h5, 32'h7, 32'h103, 32'h104, 32'h105,
                           32'h106, 32'h107, 32'h108, 32'h109, 32'h10A, 32'h10B,
                           32'h10C, 32'h10D, 32'h10E, 32'h10F};

  always #5 clk = ~clk;

  always @(posedge clk)
    if (wb_valid) rf[wb_reg] <= wb_data;

  assign rf_rd1 = rf[rr1];
  assign rf_rd2 = rf[rr2];

  operand_fetch #(.BYPASS_EN(1)) u_byp (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_readReg1(rr1), .rf_readReg2(rr2),
    .rf_readData1(rf_rd1), .rf_readData2(rf_rd2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
    .ex_rd(ex_rd), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  operand_fetch #(.BYPASS_EN(0)) u_nobyp (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready_b), .rf_readReg1(rr1_b), .rf_readReg2(rr2_b),
    .rf_readData1(rf_rd1), .rf_readData2(rf_rd2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_valid(ex_valid_b), .ex_ready(ex_ready), .ex_opcode(ex_opcode_b),
    .ex_rd(ex_rd_b), .ex_opA(ex_opA_b), .ex_opB(ex_opB_b), .ex_imm(ex_imm_b),
    .flush(flush), .stall_cnt(stall_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [15:0] im);
    return {op, d, s1, s2, im};
  endfunction

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr = '0; wb_valid = 1'b0;
    wb_reg = '0; wb_data = '0; ex_ready = 1'b0; flush = 1'b0;

    // reset state
    #2;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_busy", {16'd0, u_byp.busy}, 32'd0);
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    #10 reset = 1'b1;
    tick();

    // independent issue
    instr_valid = 1'b1; ex_ready = 1'b1;
    instr = mk(4'h0, 4'd3, 4'd1, 4'd2, 16'h00AA);
    #1;
    check("rd_addr1", {28'd0, rr1}, 32'd1);
    check("rd_addr2", {28'd0, rr2}, 32'd2);
    check("rd_addr1_b", {28'd0, rr1_b}, 32'd1);
    check("add_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("add_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("add_opA", ex_opA, 32'd5);
    check("add_opB", ex_opB, 32'd7);
    check("add_rd", {28'd0, ex_rd}, 32'd3);
    check("add_imm", {16'd0, ex_imm}, 32'h00AA);
    check("add_busy", {16'd0, u_byp.busy}, 32'h0008);

    // RAW stall resolved by forwarding
    instr = mk(4'h1, 4'd5, 4'd3, 4'd2, 16'h0);
    #1;
    check("raw_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    check("raw_ex_drain", {31'd0, ex_valid}, 32'd0);
    check("raw_cnt1", {16'd0, stall_cnt}, 32'd1);
    tick();
    check("raw_cnt2", {16'd0, stall_cnt}, 32'd2);
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 32'h1234;
    #1;
    check("raw_wb_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("raw_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("raw_opA_fwd", ex_opA, 32'h1234);
    check("raw_opB", ex_opB, 32'd7);
    check("raw_cnt_hold", {16'd0, stall_cnt}, 32'd2);
    check("raw_busy", {16'd0, u_byp.busy}, 32'h0020);
    wb_valid = 1'b0;

    // backpressure
    ex_ready = 1'b0;
    instr = mk(4'h2, 4'd6, 4'd1, 4'd2, 16'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", {31'd0, instr_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, ex_valid}, 32'd1);
      check("bp_opA", ex_opA, 32'h1234);
      check("bp_rd", {28'd0, ex_rd}, 32'd5);
    end
    check("bp_cnt", {16'd0, stall_cnt}, 32'd2);
    ex_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("bp_new_rd", {28'd0, ex_rd}, 32'd6);
    check("bp_new_opA", ex_opA, 32'd5);
    check("bp_busy", {16'd0, u_byp.busy}, 32'h0060);

    // back-to-back issue
    instr = mk(4'hC, 4'd0, 4'd1, 4'd2, 16'h0BEE);
    tick();
    check("b2b_opcode", {28'd0, ex_opcode}, 32'hC);
    check("b2b_imm", {16'd0, ex_imm}, 32'h0BEE);
    check("b2b_busy_nowr", {16'd0, u_byp.busy}, 32'h0060);
    instr = mk(4'h3, 4'd7, 4'd2, 4'd1, 16'h0001);
    tick();
    check("b2b_opA", ex_opA, 32'd7);
    check("b2b_opB", ex_opB, 32'd5);
    check("b2b_busy", {16'd0, u_byp.busy}, 32'h00E0);

    // register 0 is scoreboarded and forwarded
    instr = mk(4'h0, 4'd0, 4'd1, 4'd2, 16'h0);
    tick();
    check("r0_busy", {16'd0, u_byp.busy}, 32'h00E1);
    instr = mk(4'hC, 4'd9, 4'd1, 4'd0, 16'h0);
    #1;
    check("r0_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    check("r0_cnt", {16'd0, stall_cnt}, 32'd3);
    wb_valid = 1'b1; wb_reg = 4'd0; wb_data = 32'hABCD;
    #1;
    check("r0_wb_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("r0_opB_fwd", ex_opB, 32'hABCD);
    check("r0_busy_clr", {16'd0, u_byp.busy}, 32'h00E0);
    wb_valid = 1'b0; instr_valid = 1'b0;
    tick();
    check("drain_valid", {31'd0, ex_valid}, 32'd0);

    // simultaneous writeback/issue on rd=4, then flush
    instr_valid = 1'b1;
    instr = mk(4'h0, 4'd4, 4'd1, 4'd2, 16'h0);
    tick();
    check("sim_busy1", {16'd0, u_byp.busy}, 32'h00F0);
    instr = mk(4'h1, 4'd4, 4'd1, 4'd2, 16'h0);
    wb_valid = 1'b1; wb_reg = 4'd4; wb_data = 32'h44;
    #1;
    check("sim_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("sim_busy_set_wins", {16'd0, u_byp.busy}, 32'h00F0);
    check("sim_opcode", {28'd0, ex_opcode}, 32'h1);
    wb_valid = 1'b0; ex_ready = 1'b0; flush = 1'b1;
    instr = mk(4'hF, 4'd0, 4'd0, 4'd0, 16'h0);
    #1;
    check("flush_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_busy", {16'd0, u_byp.busy}, 32'h00E0);
    flush = 1'b0; instr_valid = 1'b0;

    // writeback to a register that is not busy
    wb_valid = 1'b1; wb_reg = 4'd9; wb_data = 32'h9;
    tick();
    check("wb_idle_busy", {16'd0, u_byp.busy}, 32'h00E0);
    wb_valid = 1'b0;

    // async reset mid-stall with a held bundle
    reset = 1'b0; #1 reset = 1'b1;
    instr_valid = 1'b1; ex_ready = 1'b1;
    instr = mk(4'h0, 4'd3, 4'd1, 4'd2, 16'h0);
    tick();
    instr = mk(4'h0, 4'd4, 4'd1, 4'd2, 16'h0);
    tick();
    ex_ready = 1'b0;
    instr = mk(4'h1, 4'd8, 4'd3, 4'd2, 16'h0);
    repeat (5) tick();
    check("pre_rst_cnt", {16'd0, stall_cnt}, 32'd5);
    check("pre_rst_busy", {16'd0, u_byp.busy}, 32'h0018);
    check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_busy", {16'd0, u_byp.busy}, 32'd0);
    check("arst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("arst_opA", ex_opA, 32'd0);
    check("arst_rd", {28'd0, ex_rd}, 32'd0);
    check("arst_imm", {16'd0, ex_imm}, 32'd0);
    check("arst_ready", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b0;
    #1 reset = 1'b1;

    // no forwarding: one extra stall cycle, operand read from register file
    instr_valid = 1'b1; ex_ready = 1'b1;
    instr = mk(4'h0, 4'd3, 4'd1, 4'd2, 16'h0);
    tick();
    check("nb_add_opA", ex_opA_b, 32'd5);
    instr = mk(4'h1, 4'd5, 4'd3, 4'd2, 16'h0);
    tick();
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 32'h1234;
    #1;
    check("nb_wb_ready", {31'd0, instr_ready_b}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("nb_ready", {31'd0, instr_ready_b}, 32'd1);
    tick();
    check("nb_valid", {31'd0, ex_valid_b}, 32'd1);
    check("nb_opA_rf", ex_opA_b, 32'h1234);
    check("nb_cnt", {16'd0, stall_cnt_b}, 32'd2);
    instr_valid = 1'b0;

    // stall counter saturation
    reset = 1'b0; #1 reset = 1'b1;
    instr_valid = 1'b1; ex_ready = 1'b1;
    instr = mk(4'h0, 4'd3, 4'd1, 4'd2, 16'h0);
    tick();
    instr = mk(4'h1, 4'd5, 4'd3, 4'd2, 16'h0);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    tick();
    check("sat_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    tick();
    tick();
    check("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);
    instr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
